// File: rtl/char_renderer_pkg.sv
// Shared constants and FSM state encoding for the character renderer.
package char_renderer_pkg;

    localparam int unsigned GLYPH_W       = 8;
    localparam int unsigned GLYPH_H       = 8;
    localparam int unsigned COLOUR_W      = 3;
    localparam int unsigned DEFAULT_X_MAX = 160;
    localparam int unsigned DEFAULT_Y_MAX = 120;

    typedef logic [1:0] state_t;

    localparam state_t StIdle = 2'd0;
    localparam state_t StLoad = 2'd1;
    localparam state_t StDraw = 2'd2;
    localparam state_t StDone = 2'd3;

endpackage

// File: rtl/glyph_scan_ctr.sv
// Raster scan counter for one 8x8 glyph cell: col runs fastest, row slowest.
module glyph_scan_ctr (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       clear_i,
    input  logic       en_i,
    output logic [2:0] col_o,
    output logic [2:0] row_o,
    output logic       last_o
);

    logic [2:0] col_q, col_d;
    logic [2:0] row_q, row_d;

    // Counter state registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            col_q <= 3'd0;
            row_q <= 3'd0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    // Clear has priority; row advances when col wraps
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clear_i) begin
            col_d = 3'd0;
            row_d = 3'd0;
        end else if (en_i) begin
            col_d = col_q + 3'd1;
            if (col_q == 3'd7) begin
                row_d = row_q + 3'd1;
            end
        end
    end

    // Outputs and last-pixel flag
    always_comb begin
        col_o  = col_q;
        row_o  = row_q;
        last_o = (col_q == 3'd7) && (row_q == 3'd7);
    end

endmodule

// File: rtl/char_renderer.sv
// Renders one 8x8 glyph from an external ROM as a stream of pixel writes.
// Optional feature macro: CHAR_RENDERER_TRANSPARENT_EN (skip plotting 0 bits).
module char_renderer
    import char_renderer_pkg::*;
#(
    parameter int unsigned X_MAX = DEFAULT_X_MAX,
    parameter int unsigned Y_MAX = DEFAULT_Y_MAX
) (
    input  logic                         clock_i,
    input  logic                         reset_i,
    input  logic                         start_i,
    input  logic [7:0]                   char_code_i,
    input  logic [7:0]                   x_origin_i,
    input  logic [6:0]                   y_origin_i,
    input  logic [COLOUR_W-1:0]          fg_colour_i,
    input  logic [COLOUR_W-1:0]          bg_colour_i,
    output logic [7:0]                   glyph_code_o,
    input  logic [GLYPH_W*GLYPH_H-1:0]   glyph_bits_i,
    output logic [7:0]                   x_o,
    output logic [6:0]                   y_o,
    output logic [COLOUR_W-1:0]          colour_o,
    output logic                         plot_o,
    output logic                         busy_o,
    output logic                         done_o
);

    state_t                       state_q, state_d;
    logic [7:0]                   code_q, code_d;
    logic [7:0]                   x_org_q, x_org_d;
    logic [6:0]                   y_org_q, y_org_d;
    logic [COLOUR_W-1:0]          fg_q, fg_d;
    logic [COLOUR_W-1:0]          bg_q, bg_d;
    logic [GLYPH_W*GLYPH_H-1:0]   glyph_q, glyph_d;

    logic       ctr_clear, ctr_en, ctr_last;
    logic [2:0] col, row;

    logic [8:0] x_sum;
    logic [7:0] y_sum;
    logic       pix_bit, in_bounds, visible, drawing;

    glyph_scan_ctr u_scan (
        .clk_i   (clock_i),
        .rst_i   (reset_i),
        .clear_i (ctr_clear),
        .en_i    (ctr_en),
        .col_o   (col),
        .row_o   (row),
        .last_o  (ctr_last)
    );

    // State and request registers
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            code_q  <= '0;
            x_org_q <= '0;
            y_org_q <= '0;
            fg_q    <= '0;
            bg_q    <= '0;
            glyph_q <= '0;
        end else begin
            state_q <= state_d;
            code_q  <= code_d;
            x_org_q <= x_org_d;
            y_org_q <= y_org_d;
            fg_q    <= fg_d;
            bg_q    <= bg_d;
            glyph_q <= glyph_d;
        end
    end

    // FSM next-state: latch request in IDLE, capture ROM row data in LOAD
    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        x_org_d   = x_org_q;
        y_org_d   = y_org_q;
        fg_d      = fg_q;
        bg_d      = bg_q;
        glyph_d   = glyph_q;
        ctr_clear = 1'b0;
        ctr_en    = 1'b0;
        case (state_q)
            StIdle: begin
                if (start_i) begin
                    code_d  = char_code_i;
                    x_org_d = x_origin_i;
                    y_org_d = y_origin_i;
                    fg_d    = fg_colour_i;
                    bg_d    = bg_colour_i;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                glyph_d   = glyph_bits_i;
                ctr_clear = 1'b1;
                state_d   = StDraw;
            end
            StDraw: begin
                ctr_en = 1'b1;
                if (ctr_last) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Pixel generation; sums are widened so clipping sees the unwrapped coordinate
    always_comb begin
        drawing   = (state_q == StDraw);
        x_sum     = {1'b0, x_org_q} + {6'b0, col};
        y_sum     = {1'b0, y_org_q} + {5'b0, row};
        // Bit 8*row + 7 - col; ~col equals 7 - col for 3-bit values
        pix_bit   = glyph_q[{row, ~col}];
        in_bounds = (32'(x_sum) < X_MAX) && (32'(y_sum) < Y_MAX);
`ifdef CHAR_RENDERER_TRANSPARENT_EN
        visible   = pix_bit;
`else
        visible   = 1'b1;
`endif
        x_o          = drawing ? x_sum[7:0] : 8'd0;
        y_o          = drawing ? y_sum[6:0] : 7'd0;
        colour_o     = drawing ? (pix_bit ? fg_q : bg_q) : '0;
        plot_o       = drawing && in_bounds && visible;
        busy_o       = (state_q != StIdle);
        done_o       = (state_q == StDone);
        glyph_code_o = code_q;
    end

endmodule

// File: tb/tb_char_renderer.sv
// Self-checking bench for char_renderer: directed and random draws vs. a pixel scoreboard.
module tb_char_renderer;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  char_code;
    logic [7:0]  x_origin;
    logic [6:0]  y_origin;
    logic [2:0]  fg_colour;
    logic [2:0]  bg_colour;
    logic [7:0]  glyph_code;
    logic [63:0] glyph_bits;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  colour;
    logic        plot;
    logic        busy;
    logic        done;

    logic [63:0] rom [256];
    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        int cyc;
        int px;
        int py;
        int col;
    } pix_t;

    assign glyph_bits = rom[glyph_code];

    always #5 clock = ~clock;

    char_renderer dut (
        .clock_i      (clock),
        .reset_i      (reset),
        .start_i      (start),
        .char_code_i  (char_code),
        .x_origin_i   (x_origin),
        .y_origin_i   (y_origin),
        .fg_colour_i  (fg_colour),
        .bg_colour_i  (bg_colour),
        .glyph_code_o (glyph_code),
        .glyph_bits_i (glyph_bits),
        .x_o          (x),
        .y_o          (y),
        .colour_o     (colour),
        .plot_o       (plot),
        .busy_o       (busy),
        .done_o       (done)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_x"}, x, 0);
        chk({tag, "_y"}, y, 0);
        chk({tag, "_colour"}, colour, 0);
        chk({tag, "_plot"}, plot, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_glyph_code"}, glyph_code, 0);
    endtask

    // One character request. Entered at a negedge with the DUT idle (cycle 0);
    // returns at the negedge of cycle 67, which is the next request's cycle 0.
    // exp_total < 0 skips the absolute plot-count check.
    task automatic draw(input logic [7:0] code, input logic [7:0] xo, input logic [6:0] yo,
                        input logic [2:0] fg, input logic [2:0] bg, input bit hold,
                        input int pulse_a, input int pulse_b, input int abort_at,
                        input int exp_total);
        pix_t expq[$];
        pix_t obsq[$];
        int   dones   = 0;
        bit   aborted = 0;

        // Reference: every cell pixel in raster order, keep those that get plotted
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                int xs = int'(xo) + c;
                int ys = int'(yo) + r;
                bit b  = rom[code][8 * r + 7 - c];
                bit vis = (xs < 160) && (ys < 120);
`ifdef CHAR_RENDERER_TRANSPARENT_EN
                vis = vis && b;
`endif
                if (vis) expq.push_back('{2 + 8 * r + c, xs % 256, ys % 128, b ? int'(fg) : int'(bg)});
            end
        end

        chk("c0_busy", busy, 0);
        chk("c0_plot", plot, 0);
        start     = 1'b1;
        char_code = code;
        x_origin  = xo;
        y_origin  = yo;
        fg_colour = fg;
        bg_colour = bg;

        for (int c = 1; c <= 67; c++) begin
            @(posedge clock);
            @(negedge clock);
            if (c == abort_at) begin
                reset = 1'b1;
                #1;
                chk_all_zero("abort");
                @(negedge clock);
                start = 1'b0;
                reset = 1'b0;
                aborted = 1;
                break;
            end
            chk("busy", busy, (c <= 66));
            chk("done", done, (c == 66));
            if (c <= 66) chk("glyph_code", glyph_code, code);
            if (done) dones++;
            if (plot) obsq.push_back('{c, int'(x), int'(y), int'(colour)});
            if (c == 1) begin
                // Request inputs are now don't-care for this draw
                char_code = 8'($urandom);
                x_origin  = 8'($urandom);
                y_origin  = 7'($urandom);
                fg_colour = 3'($urandom);
                bg_colour = 3'($urandom);
            end
            start = (c == pulse_a || c == pulse_b) ? 1'b1 : hold;
        end

        if (!aborted) begin
            chk("done_count", dones, 1);
            chk("plot_count", obsq.size(), expq.size());
            if (exp_total >= 0) chk("plot_total", obsq.size(), exp_total);
            for (int i = 0; i < obsq.size() && i < expq.size(); i++) begin
                chk("pix_cycle", obsq[i].cyc, expq[i].cyc);
                chk("pix_x", obsq[i].px, expq[i].px);
                chk("pix_y", obsq[i].py, expq[i].py);
                chk("pix_colour", obsq[i].col, expq[i].col);
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = {$urandom, $urandom};
        // Rows 7..0, MSB of each row is the leftmost column; twelve 1 bits
        rom[1] = 64'h0124_0018_813C_4000;

        reset     = 1'b1;
        start     = 1'b0;
        char_code = 8'd0;
        x_origin  = 8'd0;
        y_origin  = 7'd0;
        fg_colour = 3'd0;
        bg_colour = 3'd0;
        @(negedge clock);
        chk_all_zero("reset");
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk_all_zero("post_reset");

        // Basic character, full cell in bounds
`ifdef CHAR_RENDERER_TRANSPARENT_EN
        draw(8'd1, 8'd10, 7'd20, 3'd7, 3'd0, 0, -1, -1, -1, 12);
`else
        draw(8'd1, 8'd10, 7'd20, 3'd7, 3'd0, 0, -1, -1, -1, 64);
`endif

        // Clipped at the bottom-right corner of the screen
`ifdef CHAR_RENDERER_TRANSPARENT_EN
        draw(8'h34, 8'd156, 7'd116, 3'd7, 3'd2, 0, -1, -1, -1, -1);
`else
        draw(8'h34, 8'd156, 7'd116, 3'd7, 3'd2, 0, -1, -1, -1, 16);
`endif

        // Start pulses during DRAW and during DONE are ignored
        draw(8'd1, 8'd40, 7'd50, 3'd5, 3'd1, 0, 5, 66, -1, -1);
        repeat (3) begin
            @(posedge clock);
            @(negedge clock);
            chk("no_restart_busy", busy, 0);
            chk("no_restart_done", done, 0);
        end

        // Reset in the middle of DRAW, then a fresh full draw
        draw(8'd77, 8'd30, 7'd30, 3'd3, 3'd4, 0, -1, -1, 30, -1);
        chk_all_zero("after_abort");
`ifdef CHAR_RENDERER_TRANSPARENT_EN
        draw(8'd1, 8'd0, 7'd0, 3'd6, 3'd1, 0, -1, -1, -1, 12);
`else
        draw(8'd1, 8'd0, 7'd0, 3'd6, 3'd1, 0, -1, -1, -1, 64);
`endif

        // Back-to-back with start held high: draws at cycles 0, 67 and 134
        draw(8'd2, 8'd100, 7'd60, 3'd1, 3'd6, 1, -1, -1, -1, -1);
        draw(8'd3, 8'd155, 7'd10, 3'd2, 3'd5, 1, -1, -1, -1, -1);
        draw(8'd4, 8'd20, 7'd117, 3'd4, 3'd3, 0, -1, -1, -1, -1);

        // Random requests, including wrap-around origins
        for (int k = 0; k < 8; k++) begin
            draw(8'($urandom), 8'($urandom), 7'($urandom), 3'($urandom), 3'($urandom),
                 0, -1, -1, -1, -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
